button_event_decoder: RTL and testbench
=======================================

// Module: button_event_decoder
// PURPOSE
//   Input-side counterpart of the board LED drivers. Conditions one raw, bouncy
//   pushbutton pin into clean events for the top-level pattern logic.
//   - 2-flop synchroniser, then debounce filter.
//   - Classifies each press as short or long.
//   - Keeps a wrapping count of short clicks.
// PARAMETERS
//   DEBOUNCE_CYCLES    120000    consecutive stable samples needed to accept a level change (10 ms @ 12 MHz)
//   LONG_PRESS_CYCLES  12000000  held cycles after accepted press that make a long press (1 s @ 12 MHz)
//   ACTIVE_LOW         1         1: pin reads 0 when pressed; 0: pin reads 1 when pressed
// PORTS
//   clk            in   1  system clock (12 MHz board oscillator)
//   resetn         in   1  asynchronous, active-low reset
//   btn_pin        in   1  raw asynchronous button pin
//   btn_level      out  1  debounced level, 1 = pressed
//   press_pulse    out  1  1-cycle strobe on accepted press
//   release_pulse  out  1  1-cycle strobe on accepted release
//   short_pulse    out  1  1-cycle strobe on release when no long press fired
//   long_pulse     out  1  1-cycle strobe when hold reaches LONG_PRESS_CYCLES
//   click_count    out  4  number of short presses, mod 16
// BEHAVIOUR
//   Reset
//   - All outputs 0.
//   - Synchroniser flops load the inactive pin level (1 if ACTIVE_LOW, else 0).
//   - All counters 0; FSM in IDLE.
//   - Async assert; reset mid-press discards the press: no pulses on exit,
//     and the press is re-accepted only after a full debounce.
//   Synchroniser and polarity
//   - btn_pin passes 2 flops, then is inverted if ACTIVE_LOW.
//   - Result: sync_p, 1 = pressed.
//   Debounce counter
//   - Width $clog2(DEBOUNCE_CYCLES+1).
//   - Counts while sync_p != btn_level.
//   - Clears to 0 on any cycle where sync_p == btn_level; glitches shorter than
//     DEBOUNCE_CYCLES never propagate.
//   - When the count reaches DEBOUNCE_CYCLES-1 while still differing,
//     btn_level toggles on the next edge and the counter clears.
//   - Latency from a clean pin edge to btn_level change: 2 + DEBOUNCE_CYCLES cycles.
//   FSM states (advance on btn_level edges)
//   - IDLE -> PRESSED on rising btn_level.
//       press_pulse asserted that same cycle; hold counter cleared.
//   - PRESSED: hold counter increments each cycle.
//       Width $clog2(LONG_PRESS_CYCLES+1); saturates, never wraps.
//       Count reaches LONG_PRESS_CYCLES-1 while pressed: long_pulse asserted
//       once -> LONG_HELD.
//       Falling btn_level: release_pulse + short_pulse;
//       click_count <= click_count+1 (wraps 15->0) -> IDLE.
//   - LONG_HELD: no further long pulses however long the button is held.
//       Falling btn_level: release_pulse only (no short_pulse, count unchanged) -> IDLE.
//   - Same cycle as long threshold and falling btn_level: release wins.
//       Treated as short: no long_pulse.
//   Pulse rules
//   - press and release pulses are never asserted in the same cycle.
//   - short_pulse and long_pulse are mutually exclusive per press.
//   - All outputs are registered.
// TESTING (bench params: DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, ACTIVE_LOW=1)
//   1 Reset with pin=1
//     -> all outputs 0, click_count=0.
//   2 Pin 1->0, held 10 cycles, then 1
//     -> press_pulse 6 cycles after fall; release_pulse + short_pulse 6 cycles
//        after rise; click_count=1.
//   3 Pin low pulses of 1, 2, 3 cycles separated by 5 high cycles
//     -> no pulses; btn_level stays 0.
//   4 Pin held low 60 cycles
//     -> press_pulse; long_pulse exactly once, 19 cycles later;
//        release_pulse only; click_count unchanged.
//   5 Sixteen clean short presses
//     -> click_count 1..15 then wraps to 0.
//   6 resetn pulsed low while held (state PRESSED, hold=10), pin kept low
//     -> outputs 0; after resetn high, new press_pulse 6 cycles later;
//        no release or short pulse from the aborted press.

Source files
------------

// File: rtl/button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module  : button_event_decoder
// Brief   : Synchronises and debounces one pushbutton pin, then classifies
//           each press as short or long and counts short clicks (mod 16).
// Revision: 1.0 - initial release
// ============================================================================
module button_event_decoder #(
    parameter int DEBOUNCE_CYCLES   = 120000,
    parameter int LONG_PRESS_CYCLES = 12000000,
    parameter bit ACTIVE_LOW        = 1'b1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       btn_pin,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic [3:0] click_count
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DB_W-1:0]   c_db_last   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] c_hold_max  = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic              c_pin_idle  = ACTIVE_LOW;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_LONG_HELD = 2'd2
    } state_t;

    logic              sync1_q, sync2_q;
    logic              w_sync_p;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              level_q, level_d;
    logic              w_rise, w_fall;
    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d, w_hold_inc;
    logic [3:0]        click_q, click_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              short_q, short_d;
    logic              long_q, long_d;

    assign w_sync_p = sync2_q ^ ACTIVE_LOW;

    // Any disagreement with the accepted level restarts the stability window.
    always_comb begin
        db_cnt_d = '0;
        level_d  = level_q;
        if (w_sync_p != level_q) begin
            if (db_cnt_q == c_db_last) begin
                level_d = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Events use the next level so the pulses line up with btn_level.
    assign w_rise     = level_d & ~level_q;
    assign w_fall     = ~level_d & level_q;
    assign w_hold_inc = (hold_q == c_hold_max) ? hold_q : hold_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        click_d   = click_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_rise) begin
                    state_d = ST_PRESSED;
                    press_d = 1'b1;
                    hold_d  = '0;
                end
            end
            ST_PRESSED: begin
                // A release on the threshold cycle still counts as short.
                if (w_fall) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    short_d   = 1'b1;
                    click_d   = click_q + 1'b1;
                end else begin
                    hold_d = w_hold_inc;
                    if (w_hold_inc == c_hold_last) begin
                        long_d  = 1'b1;
                        state_d = ST_LONG_HELD;
                    end
                end
            end
            ST_LONG_HELD: begin
                if (w_fall) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                end else begin
                    hold_d = w_hold_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q   <= c_pin_idle;
            sync2_q   <= c_pin_idle;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            click_q   <= 4'd0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync1_q   <= btn_pin;
            sync2_q   <= sync1_q;
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            state_q   <= state_d;
            hold_q    <= hold_d;
            click_q   <= click_d;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_pulse   = short_q;
    assign long_pulse    = long_q;
    assign click_count   = click_q;

endmodule
`default_nettype wire

// File: tb/tb_button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_button_event_decoder
// Brief   : Self-checking bench: directed scenarios plus random pin activity
//           compared every cycle against a sample-window behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_button_event_decoder;

    localparam int DB   = 4;
    localparam int LP   = 20;
    localparam int HIST = DB + 2;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       btn_pin = 1'b1;
    logic       btn_level, press_pulse, release_pulse, short_pulse, long_pulse;
    logic [3:0] click_count;

    int n_tests = 0;
    int n_fail  = 0;

    button_event_decoder #(
        .DEBOUNCE_CYCLES  (DB),
        .LONG_PRESS_CYCLES(LP),
        .ACTIVE_LOW       (1'b1)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .btn_pin      (btn_pin),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_pulse  (short_pulse),
        .long_pulse   (long_pulse),
        .click_count  (click_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the level flips once the DB synchronised samples
    // (pin seen two edges earlier and before) all disagree with it.
    logic hist [HIST];
    int   m_level, m_pressed, m_long_fired, m_hold, m_clicks;
    int   e_press, e_release, e_short, e_long;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < HIST; i++) hist[i] = 1'b1;
            m_level = 0; m_pressed = 0; m_long_fired = 0; m_hold = 0; m_clicks = 0;
            e_press = 0; e_release = 0; e_short = 0; e_long = 0;
        end else begin
            bit all_differ;
            for (int i = HIST - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = btn_pin;
            e_press = 0; e_release = 0; e_short = 0; e_long = 0;
            all_differ = 1'b1;
            for (int k = 2; k < 2 + DB; k++)
                if (int'(!hist[k]) == m_level) all_differ = 1'b0;
            if (all_differ) begin
                m_level = 1 - m_level;
                if (m_level == 1) begin
                    e_press = 1; m_pressed = 1; m_hold = 0; m_long_fired = 0;
                end else begin
                    e_release = 1; m_pressed = 0;
                    if (m_long_fired == 0) begin
                        e_short  = 1;
                        m_clicks = (m_clicks + 1) % 16;
                    end
                end
            end else if (m_pressed == 1) begin
                m_hold++;
                if (m_long_fired == 0 && m_hold == LP - 1) begin
                    e_long = 1; m_long_fired = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("model btn_level",     int'(btn_level),     m_level);
        check("model press_pulse",   int'(press_pulse),   e_press);
        check("model release_pulse", int'(release_pulse), e_release);
        check("model short_pulse",   int'(short_pulse),   e_short);
        check("model long_pulse",    int'(long_pulse),    e_long);
        check("model click_count",   int'(click_count),   m_clicks);
    end

    int n_press = 0, n_release = 0, n_short = 0, n_long = 0, n_level_hi = 0;
    always @(negedge clk) begin
        if (press_pulse)   n_press++;
        if (release_pulse) n_release++;
        if (short_pulse)   n_short++;
        if (long_pulse)    n_long++;
        if (btn_level)     n_level_hi++;
    end

    function automatic logic sig(input int sel);
        case (sel)
            0:       return press_pulse;
            1:       return release_pulse;
            default: return long_pulse;
        endcase
    endfunction

    // Counts edges from the current point until the selected strobe is seen.
    task automatic wait_for(input int sel, input int limit, output int n);
        n = 0;
        while (1) begin
            @(posedge clk); #1;
            n++;
            if (sig(sel)) return;
            if (n >= limit) begin
                n = -1;
                return;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); #2 resetn = 1'b0;
        @(negedge clk); #2 resetn = 1'b1;
    endtask

    initial begin
        int n, p0, r0, s0, l0, h0;
        #1 resetn = 1'b0;
        @(negedge clk); #2 resetn = 1'b1;

        // Reset state
        @(negedge clk);
        check("reset btn_level", int'(btn_level), 0);
        check("reset click_count", int'(click_count), 0);
        check("reset pulses", int'({press_pulse, release_pulse, short_pulse, long_pulse}), 0);

        // Clean short press
        @(negedge clk); btn_pin = 1'b0;
        wait_for(0, 20, n);
        check("short press latency", n, 6);
        repeat (4) @(negedge clk);
        btn_pin = 1'b1;
        wait_for(1, 20, n);
        check("short release latency", n, 6);
        check("short pulse with release", int'(short_pulse), 1);
        check("click after first short", int'(click_count), 1);

        // Glitches shorter than the debounce window
        @(posedge clk);
        p0 = n_press; h0 = n_level_hi;
        for (int w = 1; w <= 3; w++) begin
            @(negedge clk); btn_pin = 1'b0;
            repeat (w) @(negedge clk);
            btn_pin = 1'b1;
            repeat (5) @(negedge clk);
        end
        @(posedge clk);
        check("glitch press count", n_press - p0, 0);
        check("glitch level high cycles", n_level_hi - h0, 0);

        // Long press held 60 cycles
        @(negedge clk); btn_pin = 1'b0;
        l0 = n_long; s0 = n_short;
        wait_for(0, 20, n);
        check("long press latency", n, 6);
        wait_for(2, 40, n);
        check("long pulse after press", n, 19);
        repeat (35) @(negedge clk);
        btn_pin = 1'b1;
        wait_for(1, 20, n);
        check("long release latency", n, 6);
        check("no short on long release", int'(short_pulse), 0);
        check("click after long", int'(click_count), 1);
        @(posedge clk);
        check("long pulse count", n_long - l0, 1);
        check("short count over long", n_short - s0, 0);

        // Sixteen short presses from a fresh reset
        pulse_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); btn_pin = 1'b0;
            repeat (8) @(negedge clk);
            btn_pin = 1'b1;
            wait_for(1, 20, n);
            check("wrap release latency", n, 6);
            check("wrap click_count", int'(click_count), (i + 1) % 16);
        end

        // Reset in the middle of a press
        @(negedge clk); btn_pin = 1'b0;
        wait_for(0, 20, n);
        check("abort press latency", n, 6);
        repeat (10) @(posedge clk);
        r0 = n_release; s0 = n_short;
        @(negedge clk); #2 resetn = 1'b0;
        #1;
        check("abort reset btn_level", int'(btn_level), 0);
        @(negedge clk); #2 resetn = 1'b1;
        wait_for(0, 20, n);
        check("re-press after reset", n, 6);
        check("no release from aborted press", n_release - r0, 0);
        check("no short from aborted press", n_short - s0, 0);
        @(negedge clk); btn_pin = 1'b1;
        repeat (12) @(negedge clk);

        // Random pin activity with occasional resets
        for (int s = 0; s < 300; s++) begin
            int dur;
            btn_pin = 1'($urandom_range(0, 1));
            dur = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45))
                                              : int'($urandom_range(1, 10));
            repeat (dur) @(negedge clk);
            if ($urandom_range(0, 60) == 0) pulse_reset();
        end
        btn_pin = 1'b1;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 5000000", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
